// File: rtl/store_drain_buffer.sv
// Committed-store FIFO in front of a single-port data memory: drains one store
// per idle cycle, yields the port to loads and forwards the youngest matching store.
module store_drain_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    output logic              push_ready,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [PTR_W:0]    count;
    logic              push_acc;
    logic              drain;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              hit_d;
    logic [DATA_W-1:0] hit_data_d;
    logic [PTR_W-1:0]  idx;

    assign push_ready = (count != FULL_CNT);
    assign empty      = (count == '0);
    assign push_acc   = push_valid && push_ready;
    assign mem_we     = (count != '0) && !ld_req;
    assign drain      = mem_we;
    assign mem_addr   = ld_req ? ld_addr : entry_addr[head_ptr];
    assign mem_wdata  = entry_data[head_ptr];
    assign ld_data    = fwd_hit ? fwd_data : mem_rdata;

    // Scan oldest to youngest so later matches override; the accepting push is youngest of all.
    always_comb begin
        hit_d      = 1'b0;
        hit_data_d = '0;
        idx        = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_ptr + PTR_W'(i);
            if (((PTR_W + 1)'(i) < count) && (entry_addr[idx] == ld_addr)) begin
                hit_d      = 1'b1;
                hit_data_d = entry_data[idx];
            end
        end
        if (push_acc && (push_addr == ld_addr)) begin
            hit_d      = 1'b1;
            hit_data_d = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            entry_addr[tail_ptr] <= push_addr;
            entry_data[tail_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            ld_valid <= 1'b0;
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
        end else begin
            if (push_acc) tail_ptr <= tail_ptr + PTR_W'(1);
            if (drain)    head_ptr <= head_ptr + PTR_W'(1);
            case ({push_acc, drain})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            ld_valid <= ld_req;
            fwd_hit  <= ld_req && hit_d;
            if (ld_req && hit_d) fwd_data <= hit_data_d;
        end
    end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Self-checking bench for store_drain_buffer: directed scenarios plus a
// randomized run against a queue-based model of the buffer.
module tb_store_drain_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk;
    logic          reset;
    logic          push_valid;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;
    logic          push_ready;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          empty;

    store_drain_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_addr(push_addr), .push_data(push_data),
        .push_ready(push_ready),
        .ld_req(ld_req), .ld_addr(ld_addr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        mq[$];
    logic          exp_ldv;
    logic          exp_hit;
    logic [DW-1:0] exp_fdata;
    int            errors;
    int            checks;
    int            wr_cnt;

    always @(posedge clk) if (mem_we === 1'b1) wr_cnt <= wr_cnt + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic set_in(input logic pv, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                          input logic lr, input logic [AW-1:0] la, input logic [DW-1:0] rd);
        push_valid = pv; push_addr = pa; push_data = pd;
        ld_req = lr; ld_addr = la; mem_rdata = rd;
    endtask

    // Model step from the buffer's rules, then move to 1 time unit after the next edge.
    task automatic advance();
        logic acc;
        logic we;
        acc = push_valid && (mq.size() < DEPTH);
        we  = (mq.size() != 0) && !ld_req;
        exp_ldv = ld_req;
        exp_hit = 1'b0;
        if (ld_req) begin
            if (acc && push_addr == ld_addr) begin
                exp_hit = 1'b1; exp_fdata = push_data;
            end else begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (mq[i].addr == ld_addr) begin
                        exp_hit = 1'b1; exp_fdata = mq[i].data; break;
                    end
                end
            end
        end
        if (we) void'(mq.pop_front());
        if (acc) mq.push_back('{addr: push_addr, data: push_data});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, '0, '0, 0, '0, '0);
        mq.delete(); exp_ldv = 0; exp_hit = 0; exp_fdata = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL reset_push_ready: got %b expected 1", push_ready); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (ld_valid !== 1'b0) begin errors++; $display("FAIL reset_ld_valid: got %b expected 0", ld_valid); end
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_push();
        set_in(1, 32'h10, 32'hAAAA0001, 0, '0, '0);
        #1;
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", push_ready); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL single_no_early_drain: got %b expected 0", mem_we); end
        advance();
        set_in(0, '0, '0, 0, '0, '0);
        #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL single_we: got %b expected 1", mem_we); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL single_addr: got %h expected 00000010", mem_addr); end
        checks++; if (mem_wdata !== 32'hAAAA0001) begin errors++; $display("FAIL single_wdata: got %h expected aaaa0001", mem_wdata); end
        advance();
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", empty); end
    endtask

    task automatic test_fill_blocked();
        int n;
        for (int i = 0; i < 4; i++) begin
            set_in(1, 32'(i * 4), $urandom, 1, 32'h100, $urandom);
            #1;
            checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b expected 1", i, push_ready); end
            checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fill_stall_%0d: got %b expected 0", i, mem_we); end
            advance();
        end
        set_in(1, 32'h10, 32'hBAD0BAD0, 1, 32'h100, $urandom);
        #1;
        checks++; if (push_ready !== 1'b0) begin errors++; $display("FAIL fill_full: got %b expected 0", push_ready); end
        advance();
        for (int i = 0; i < 4; i++) begin
            set_in(0, '0, '0, 0, '0, '0);
            #1;
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL drain_we_%0d: got %b expected 1", i, mem_we); end
            checks++; if (mem_addr !== 32'(i * 4)) begin errors++; $display("FAIL drain_addr_%0d: got %h expected %h", i, mem_addr, 32'(i * 4)); end
            checks++; if (mem_wdata !== mq[0].data) begin errors++; $display("FAIL drain_data_%0d: got %h expected %h", i, mem_wdata, mq[0].data); end
            advance();
        end
        #1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty); end
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h50 + 32'(i * 4), $urandom, 1, 32'h100, '0);
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            set_in(1, 32'h60 + 32'(i * 4), $urandom, 0, '0, '0);
            #1;
            checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL pd_we_%0d: got %b expected 1", i, mem_we); end
            checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL pd_ready_%0d: got %b expected 1", i, push_ready); end
            advance();
        end
        set_in(0, '0, '0, 1, 32'h100, '0);
        #1;
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL pd_count_kept: got %b expected 1", push_ready); end
        n = 0;
        while (mq.size() != 0 && n < 10) begin
            set_in(0, '0, '0, 0, '0, '0);
            #1;
            checks++; if (mem_we !== 1'b1 || mem_addr !== mq[0].addr || mem_wdata !== mq[0].data) begin
                errors++; $display("FAIL pd_drain_%0d: got we=%b %h/%h expected 1 %h/%h", n, mem_we, mem_addr, mem_wdata, mq[0].addr, mq[0].data);
            end
            advance();
            n++;
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pd_empty: got %b expected 1", empty); end
    endtask

    task automatic test_forward_youngest();
        set_in(1, 32'h20, 32'h11, 1, 32'h200, '0); advance();
        set_in(1, 32'h20, 32'h22, 1, 32'h200, '0); advance();
        set_in(0, '0, '0, 1, 32'h20, '0);
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL fwd_no_write: got %b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h20) begin errors++; $display("FAIL fwd_mem_addr: got %h expected 00000020", mem_addr); end
        advance();
        set_in(0, '0, '0, 1, 32'h300, 32'h0BADF00D);
        #1;
        checks++; if (ld_valid !== 1'b1) begin errors++; $display("FAIL fwd_valid: got %b expected 1", ld_valid); end
        checks++; if (ld_data !== 32'h22) begin errors++; $display("FAIL fwd_youngest: got %h expected 00000022", ld_data); end
        advance();
        set_in(0, '0, '0, 0, '0, 32'h12345678);
        #1;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 32'h12345678) begin
            errors++; $display("FAIL b2b_miss: got v=%b %h expected 1 12345678", ld_valid, ld_data);
        end
        repeat (3) begin set_in(0, '0, '0, 0, '0, '0); advance(); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fwd_drained: got %b expected 1", empty); end
    endtask

    task automatic test_load_miss();
        set_in(0, '0, '0, 1, 32'h40, '0); advance();
        set_in(0, '0, '0, 0, '0, 32'hDEADBEEF);
        #1;
        checks++; if (ld_valid !== 1'b1) begin errors++; $display("FAIL miss_valid: got %b expected 1", ld_valid); end
        checks++; if (ld_data !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_data: got %h expected deadbeef", ld_data); end
        advance();
    endtask

    task automatic test_push_forward();
        set_in(1, 32'h30, 32'h55, 1, 32'h30, '0); advance();
        set_in(0, '0, '0, 0, '0, 32'hCAFE0000);
        #1;
        checks++; if (ld_valid !== 1'b1 || ld_data !== 32'h55) begin
            errors++; $display("FAIL same_cycle_fwd: got v=%b %h expected 1 00000055", ld_valid, ld_data);
        end
        checks++; if (mem_we !== 1'b1 || mem_addr !== 32'h30) begin
            errors++; $display("FAIL same_cycle_drain: got we=%b %h expected 1 00000030", mem_we, mem_addr);
        end
        advance();
    endtask

    task automatic test_reset_mid_drain();
        int snap;
        for (int i = 0; i < 3; i++) begin
            set_in(1, 32'h70 + 32'(i * 4), $urandom, 1, 32'h400, '0); advance();
        end
        set_in(0, '0, '0, 0, '0, '0);
        #1;
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %b expected 1", mem_we); end
        reset = 1'b1;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_we: got %b expected 0", mem_we); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", empty); end
        checks++; if (push_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", push_ready); end
        mq.delete(); exp_ldv = 0; exp_hit = 0;
        snap = wr_cnt;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) advance();
        checks++; if (wr_cnt !== snap) begin errors++; $display("FAIL rst_no_writes: got %0d expected %0d", wr_cnt, snap); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 9) < 6), 32'($urandom_range(0, 7) * 4), $urandom,
                   ($urandom_range(0, 9) < 4), 32'($urandom_range(0, 7) * 4), $urandom);
            #1;
            checks++; if (push_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", c, push_ready, mq.size() != DEPTH); end
            checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty@%0d: got %b expected %b", c, empty, mq.size() == 0); end
            checks++; if (mem_we !== (mq.size() != 0 && !ld_req)) begin errors++; $display("FAIL rnd_we@%0d: got %b expected %b", c, mem_we, mq.size() != 0 && !ld_req); end
            if (ld_req) begin
                checks++; if (mem_addr !== ld_addr) begin errors++; $display("FAIL rnd_ldaddr@%0d: got %h expected %h", c, mem_addr, ld_addr); end
            end else if (mq.size() != 0) begin
                checks++; if (mem_addr !== mq[0].addr || mem_wdata !== mq[0].data) begin
                    errors++; $display("FAIL rnd_head@%0d: got %h/%h expected %h/%h", c, mem_addr, mem_wdata, mq[0].addr, mq[0].data);
                end
            end
            checks++; if (ld_valid !== exp_ldv) begin errors++; $display("FAIL rnd_ldv@%0d: got %b expected %b", c, ld_valid, exp_ldv); end
            if (exp_ldv) begin
                checks++; if (ld_data !== (exp_hit ? exp_fdata : mem_rdata)) begin
                    errors++; $display("FAIL rnd_lddata@%0d: got %h expected %h", c, ld_data, exp_hit ? exp_fdata : mem_rdata);
                end
            end
            advance();
        end
    endtask

    initial begin
        errors = 0; checks = 0; wr_cnt = 0;
        test_reset();
        test_single_push();
        test_fill_blocked();
        test_forward_youngest();
        test_load_miss();
        test_push_forward();
        test_reset_mid_drain();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- Committed-store buffer sitting directly upstream of the single-port synchronous data memory.
- Accepts stores in commit order, holds them in a FIFO and drains them one per cycle into the memory write port.
- Arbitrates the single memory port between drains and loads; loads always win.
- Forwards the youngest buffered store data to loads that hit in the buffer, aligned to the memory's one-cycle read latency.

Parameters:
- DEPTH, 4, number of buffered stores; power of 2, minimum 2.
- ADDR_W, `ADDR_LEN (32), address width.
- DATA_W, `DATA_LEN (32), data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- push_valid  in  1  committed store presented.
- push_addr  in  ADDR_W  store address.
- push_data  in  DATA_W  store data.
- push_ready  out  1  buffer can accept a store this cycle (not full).
- ld_req  in  1  load issued this cycle.
- ld_addr  in  ADDR_W  load address.
- mem_addr  out  ADDR_W  address to memory (ld_addr when ld_req, else head address).
- mem_wdata  out  DATA_W  head data.
- mem_we  out  1  write enable to memory.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after the request.
- ld_valid  out  1  load result valid; asserted one cycle after ld_req.
- ld_data  out  DATA_W  load result (forwarded data or mem_rdata).
- empty  out  1  no buffered stores.

Behaviour:
- Storage: circular array of DEPTH entries {addr, data}.
  - head_ptr and tail_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Reset (asynchronous, immediate):
  - head_ptr=0, tail_ptr=0, count=0.
  - ld_valid=0, forwarding registers=0.
  - Combinational outputs follow: push_ready=1, empty=1, mem_we=0.
  - Entry array contents are not reset.
  - Reset mid-drain discards all buffered stores; no further writes issue.
- Push:
  - push_ready = (count != DEPTH).
  - Accepted when push_valid && push_ready; the entry is written at tail_ptr and tail_ptr increments.
  - push_valid while full is ignored; the source must hold it.
  - No same-cycle bypass into a full buffer, even if a drain occurs that cycle.
- Drain:
  - mem_we = (count != 0) && !ld_req.
  - mem_addr/mem_wdata = head entry when not loading.
  - When mem_we=1, head_ptr increments at the clock edge.
  - A store pushed into an empty buffer at edge N is eligible to drain in cycle N+1 at the earliest (minimum one cycle in buffer).
- Simultaneous push and drain: count unchanged, both pointers advance.
- Load arbitration: ld_req=1 forces mem_we=0 and mem_addr=ld_addr for that cycle. The drain stalls; no entry is lost.
- Forwarding lookup (combinational, in the ld_req cycle):
  - Compares the full ld_addr against every valid entry (head..tail-1) and against the accepting push in the same cycle.
  - Priority is youngest first: the same-cycle push, then tail-1 down to head.
  - On a hit, the matched data is registered into fwd_data and fwd_hit=1 at the edge; otherwise fwd_hit=0.
- Load response (cycle after ld_req):
  - ld_valid=1.
  - ld_data = fwd_hit ? fwd_data : mem_rdata.
  - ld_valid is a registered copy of ld_req; back-to-back loads produce back-to-back results.
- Continuous loads starve the drain. Upstream must throttle on push_ready; the block provides no starvation counter.
- Address comparison is exact, full-width, with no byte masking. All stores are full words.
- empty = (count == 0).

Test Plan:
- Reset, then push {0x10, 0xAAAA0001} in cycle 1 → push_ready stays 1; cycle 2 mem_we=1, mem_addr=0x10, mem_wdata=0xAAAA0001; cycle 3 empty=1.
- With drain blocked by continuous ld_req, push 4 stores to 0x0,0x4,0x8,0xC → push_ready=0 after the 4th; a 5th push_valid is ignored. Drop ld_req → 4 writes on consecutive cycles in order, then empty=1. Also check simultaneous push+drain at full-1 keeps count constant.
- Buffer holds 0x20→0x11 then 0x20→0x22 (younger); ld_req addr 0x20 → next cycle ld_valid=1, ld_data=0x22, and no mem write in the load cycle.
- ld_req addr 0x40 with no match and mem_rdata=0xDEADBEEF on the following cycle → ld_data=0xDEADBEEF.
- Push 0x30→0x55 and ld_req 0x30 in the same cycle into an empty buffer → ld_data=0x55.
- Assert reset while 3 entries are buffered and mem_we=1 → mem_we=0 immediately, empty=1; no writes occur after reset deasserts.
